instr_fetch: RTL and testbench

//  Fetch stage directly upstream of instr_decoder: owns the PC, issues one instruction-memory read at a time,
//  and registers the returned word plus its PC into the instruction register that feeds instr_decoder.

---
 rtl/instr_fetch_pkg.sv | 16 +
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch_skid.sv | 36 +++
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: state encoding, NOP bubble word and bus widths.
// Imported by the fetch top, its skid buffer and the instruction-memory interface.
package instr_fetch_pkg;

   localparam int INSTR_WIDTH       = 32;
   localparam int FETCH_STATE_WIDTH = 2;

   localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [FETCH_STATE_WIDTH-1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface instr_fetch_if
   import instr_fetch_pkg::*;
#(
   parameter int N = 32
);

   logic                   imem_req_valid;
   logic                   imem_req_ready;
   logic [N-1:0]           imem_addr;
   logic                   imem_resp_valid;
   logic [INSTR_WIDTH-1:0] imem_resp_data;

   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data
   );

endinterface

// File: rtl/instr_fetch_skid.sv
// One-entry instruction+PC buffer that catches a returning word while the decoder is stalled.
module instr_fetch_skid
   import instr_fetch_pkg::*;
#(
   parameter int N = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic                   unload,
   input  logic                   clear,
   input  logic [INSTR_WIDTH-1:0] load_instr,
   input  logic [N-1:0]           load_pc,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [N-1:0]           pc,
   output logic                   valid
);

   // A redirect clear wins over a load arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= 1'b0;
         instr <= INSTR_NOP;
         pc    <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= load_instr;
         pc    <= load_pc;
      end else if (unload) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, keeps one instruction-memory read in flight and fills the
// instruction register feeding instr_decoder, with stall skid, branch redirect and stale-response drop.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int           N        = 32,
   parameter logic [N-1:0] RESET_PC = '0,
   parameter int           PC_STEP  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   instr_fetch_if.master          imem,
   input  logic                   stall,
   input  logic                   branch_taken,
   input  logic [N-1:0]           branch_target,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [N-1:0]           instr_pc,
   output logic                   instr_valid,
   output logic                   controlOverride
);

   localparam logic [N-1:0] PC_INC = N'(PC_STEP);

   fetch_state_e           state;
   logic [N-1:0]           pc;
   logic                   drop;
   logic                   req_fire;
   logic                   skid_load;
   logic                   skid_unload;
   logic                   skid_clear;
   logic [INSTR_WIDTH-1:0] skid_instr;
   logic [N-1:0]           skid_pc;
   logic                   skid_valid;

   assign imem.imem_req_valid = rst && (state == S_REQ);
   assign imem.imem_addr      = pc;
   assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;
   assign controlOverride     = !instr_valid;

   always_comb begin
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = branch_taken;
      if (!branch_taken) begin
         case (state)
            S_WAIT:  skid_load   = imem.imem_resp_valid && !drop && stall && instr_valid;
            S_HOLD:  skid_unload = !stall;
            default: ;
         endcase
      end
   end

   instr_fetch_skid #(.N(N)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .load       (skid_load),
      .unload     (skid_unload),
      .clear      (skid_clear),
      .load_instr (imem.imem_resp_data),
      .load_pc    (pc),
      .instr      (skid_instr),
      .pc         (skid_pc),
      .valid      (skid_valid)
   );

   // A redirect overrides everything; if a read is (or just became) outstanding we must
   // wait for it and throw it away, otherwise the next request goes straight to the target.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         drop        <= 1'b0;
         instr       <= INSTR_NOP;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else if (branch_taken) begin
         pc          <= branch_target;
         instr       <= INSTR_NOP;
         instr_valid <= 1'b0;
         if ((state == S_WAIT && !imem.imem_resp_valid) || (state == S_REQ && req_fire)) begin
            drop  <= 1'b1;
            state <= S_WAIT;
         end else begin
            drop  <= 1'b0;
            state <= S_REQ;
         end
      end else begin
         if (!stall) begin
            instr_valid <= 1'b0;
            instr       <= INSTR_NOP;
         end
         case (state)
            S_REQ: begin
               if (req_fire) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem.imem_resp_valid) begin
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= S_REQ;
                  end else if (!stall || !instr_valid) begin
                     instr       <= imem.imem_resp_data;
                     instr_pc    <= pc;
                     instr_valid <= 1'b1;
                     pc          <= pc + PC_INC;
                     state       <= S_REQ;
                  end else begin
                     pc    <= pc + PC_INC;
                     state <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!stall && skid_valid) begin
                  instr       <= skid_instr;
                  instr_pc    <= skid_pc;
                  instr_valid <= 1'b1;
                  state       <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic, checked against a program-order
// model (epoch-tagged requests, expected fetch/consume PCs) and a second DUT reset at 32'hFFFFFFFC.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

   typedef struct {
      int          due;
      logic [31:0] addr;
      int          epoch;
      int          gen;
   } req_t;

   logic        clk = 1'b0;
   logic        rst, ready, stall, branch_taken, resp_valid;
   logic [31:0] branch_target, resp_data;
   logic [31:0] instr, instr_pc, w_instr, w_instr_pc;
   logic        instr_valid, control_override, w_instr_valid, w_control_override;

   always #5 clk = ~clk;

   instr_fetch_if #(.N(32)) bus ();
   instr_fetch_if #(.N(32)) wbus ();

   assign bus.imem_req_ready   = ready;
   assign bus.imem_resp_valid  = resp_valid;
   assign bus.imem_resp_data   = resp_data;
   assign wbus.imem_req_ready  = ready;
   assign wbus.imem_resp_valid = resp_valid;
   assign wbus.imem_resp_data  = resp_data;

   instr_fetch #(.N(32), .RESET_PC(32'h0), .PC_STEP(4)) u_dut (
      .clk(clk), .rst(rst), .imem(bus.master), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .controlOverride(control_override)
   );

   instr_fetch #(.N(32), .RESET_PC(WRAP_PC), .PC_STEP(4)) u_wrap (
      .clk(clk), .rst(rst), .imem(wbus.master), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .instr(w_instr), .instr_pc(w_instr_pc),
      .instr_valid(w_instr_valid), .controlOverride(w_control_override)
   );

   req_t        pend[$];
   int          cyc, k, epoch, gen;
   int          tests_run, tests_failed;
   logic [31:0] fetch_pc, consume_pc, wrap_off, exp_pc, hold_instr, hold_pc;
   bit          exp_load, exp_hold, exp_flush, exp_reset, prev_branch;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0050_0093;
         32'h4:   return 32'h00A0_0113;
         32'h8:   return 32'h0020_81B3;
         default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One clock cycle: play memory, check last edge's expectations, update the model, advance.
   task automatic applyStimulus();
      int  resp_idx = -1;
      bit  busy;
      bit  useful;
      req_t e;
      resp_valid = 1'b0;
      resp_data  = '0;
      foreach (pend[i]) if (pend[i].due == cyc) resp_idx = i;
      if (resp_idx >= 0) begin
         resp_valid = 1'b1;
         resp_data  = mem_word(pend[resp_idx].addr);
      end
      #1;
      if (exp_flush) checkOutput("flush_valid", 32'(instr_valid), 32'd0);
      if (exp_load) begin
         checkOutput("load_valid", 32'(instr_valid), 32'd1);
         checkOutput("load_pc", instr_pc, exp_pc);
      end
      if (exp_hold) begin
         checkOutput("hold_valid", 32'(instr_valid), 32'd1);
         checkOutput("hold_instr", instr, hold_instr);
         checkOutput("hold_pc", instr_pc, hold_pc);
      end
      if (exp_reset) begin
         checkOutput("reset_valid", 32'(instr_valid), 32'd0);
         checkOutput("reset_instr", instr, INSTR_NOP);
         checkOutput("reset_pc", instr_pc, 32'd0);
      end
      exp_load = 0; exp_hold = 0; exp_flush = 0; exp_reset = 0;
      if (!rst) begin
         checkOutput("reset_req_valid", 32'(bus.imem_req_valid), 32'd0);
         gen++;
         epoch++;
         fetch_pc   = 32'h0;
         consume_pc = 32'h0;
         wrap_off   = WRAP_PC;
         exp_reset  = 1;
         if (resp_idx >= 0) pend.delete(resp_idx);
      end else begin
         checkOutput("override", 32'(control_override), 32'(!instr_valid));
         checkOutput("wrap_req_valid", 32'(wbus.imem_req_valid), 32'(bus.imem_req_valid));
         checkOutput("wrap_valid", 32'(w_instr_valid), 32'(instr_valid));
         checkOutput("wrap_override", 32'(w_control_override), 32'(control_override));
         checkOutput("wrap_instr", w_instr, instr);
         if (bus.imem_req_valid) checkOutput("wrap_addr", wbus.imem_addr, bus.imem_addr + wrap_off);
         if (instr_valid) checkOutput("wrap_instr_pc", w_instr_pc, instr_pc + wrap_off);
         busy = 0;
         foreach (pend[i]) if (pend[i].gen == gen) busy = 1;
         if (busy) checkOutput("one_outstanding", 32'(bus.imem_req_valid), 32'd0);
         if (bus.imem_req_valid && ready) begin
            checkOutput("req_addr", bus.imem_addr, fetch_pc);
            pend.push_back('{due: cyc + k, addr: bus.imem_addr, epoch: epoch, gen: gen});
         end
         if (resp_idx >= 0) begin
            e = pend[resp_idx];
            pend.delete(resp_idx);
            useful = (e.gen == gen) && (e.epoch == epoch) && !branch_taken;
            if (useful) begin
               fetch_pc = fetch_pc + 32'd4;
               if (!stall || !instr_valid) begin
                  exp_load = 1;
                  exp_pc   = e.addr;
               end
            end
         end
         if (instr_valid && !stall) begin
            checkOutput("consume_pc", instr_pc, consume_pc);
            checkOutput("consume_data", instr, mem_word(consume_pc));
            consume_pc = consume_pc + 32'd4;
         end else if (instr_valid && stall && !branch_taken) begin
            exp_hold   = 1;
            hold_instr = instr;
            hold_pc    = instr_pc;
         end
         if (branch_taken) begin
            epoch++;
            fetch_pc   = branch_target;
            consume_pc = branch_target;
            wrap_off   = 32'h0;
            exp_load   = 0;
            exp_hold   = 0;
            exp_flush  = 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      rst = 1'b0; ready = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      resp_valid = 1'b0; resp_data = '0;
      cyc = 0; k = 1; epoch = 0; gen = 0; tests_run = 0; tests_failed = 0;
      fetch_pc = '0; consume_pc = '0; wrap_off = WRAP_PC; exp_pc = '0; hold_instr = '0; hold_pc = '0;
      exp_load = 0; exp_hold = 0; exp_flush = 0; exp_reset = 0; prev_branch = 0;
      @(negedge clk);

      // Reset, then three back-to-back fetches with one-cycle memory latency.
      applyStimulus();
      applyStimulus();
      rst = 1'b1;
      #1;
      checkOutput("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
      checkOutput("first_req_addr", bus.imem_addr, 32'h0);
      checkOutput("first_override", 32'(control_override), 32'd1);
      checkOutput("wrap_first_addr", wbus.imem_addr, WRAP_PC);
      applyStimulus();
      checkOutput("pre_word_override", 32'(control_override), 32'd1);
      applyStimulus();
      checkOutput("w0_valid", 32'(instr_valid), 32'd1);
      checkOutput("w0_instr", instr, 32'h0050_0093);
      checkOutput("w0_pc", instr_pc, 32'h0);
      checkOutput("w0_override", 32'(control_override), 32'd0);
      checkOutput("wrap_second_addr", wbus.imem_addr, 32'h0);
      applyStimulus();
      applyStimulus();
      checkOutput("w1_instr", instr, 32'h00A0_0113);
      checkOutput("w1_pc", instr_pc, 32'h4);
      applyStimulus();
      applyStimulus();
      checkOutput("w2_instr", instr, 32'h0020_81B3);
      checkOutput("w2_pc", instr_pc, 32'h8);
      checkOutput("w2_valid", 32'(instr_valid), 32'd1);

      // Memory refuses the request for five cycles: address must stay put.
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("nr_req_valid", 32'(bus.imem_req_valid), 32'd1);
         checkOutput("nr_addr", bus.imem_addr, 32'hC);
         applyStimulus();
      end
      checkOutput("nr_instr_valid", 32'(instr_valid), 32'd0);
      ready = 1'b1;

      // Stall while the second word returns: word@4 parks in the skid buffer.
      rst = 1'b0;
      applyStimulus();
      rst = 1'b1;
      applyStimulus();
      applyStimulus();
      stall = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("skid_hold_instr", instr, 32'h0050_0093);
      checkOutput("skid_hold_pc", instr_pc, 32'h0);
      checkOutput("skid_no_req", 32'(bus.imem_req_valid), 32'd0);
      applyStimulus();
      checkOutput("skid_no_req2", 32'(bus.imem_req_valid), 32'd0);
      stall = 1'b0;
      applyStimulus();
      checkOutput("skid_out_instr", instr, 32'h00A0_0113);
      checkOutput("skid_out_pc", instr_pc, 32'h4);
      checkOutput("after_skid_req", 32'(bus.imem_req_valid), 32'd1);
      checkOutput("after_skid_addr", bus.imem_addr, 32'h8);

      // Redirect to 0x100 while the read of 8 is in flight (latency 3).
      k = 3;
      applyStimulus();
      branch_taken = 1'b1; branch_target = 32'h100;
      applyStimulus();
      branch_taken = 1'b0;
      checkOutput("br_flush_valid", 32'(instr_valid), 32'd0);
      checkOutput("br_wait_req", 32'(bus.imem_req_valid), 32'd0);
      applyStimulus();
      checkOutput("br_stale_req", 32'(bus.imem_req_valid), 32'd0);
      applyStimulus();
      checkOutput("br_target_req", 32'(bus.imem_req_valid), 32'd1);
      checkOutput("br_target_addr", bus.imem_addr, 32'h100);
      applyStimulus();
      for (int i = 0; i < 3; i++) begin
         checkOutput("br_bubble", 32'(instr_valid), 32'd0);
         applyStimulus();
      end
      checkOutput("br_word_valid", 32'(instr_valid), 32'd1);
      checkOutput("br_word_pc", instr_pc, 32'h100);

      // Redirect in the same cycle as a response: that response is discarded, no drop pending.
      k = 1;
      applyStimulus();
      branch_taken = 1'b1; branch_target = 32'h200;
      applyStimulus();
      branch_taken = 1'b0;
      checkOutput("same_cyc_valid", 32'(instr_valid), 32'd0);
      checkOutput("same_cyc_req", 32'(bus.imem_req_valid), 32'd1);
      checkOutput("same_cyc_addr", bus.imem_addr, 32'h200);

      // Reset while waiting; the response arriving afterwards is ignored.
      k = 2;
      applyStimulus();
      rst = 1'b0;
      applyStimulus();
      rst = 1'b1;
      #1;
      checkOutput("post_rst_req", 32'(bus.imem_req_valid), 32'd1);
      checkOutput("post_rst_addr", bus.imem_addr, 32'h0);
      applyStimulus();
      checkOutput("post_rst_ignored", 32'(instr_valid), 32'd0);
      applyStimulus();
      applyStimulus();
      checkOutput("post_rst_word_valid", 32'(instr_valid), 32'd1);
      checkOutput("post_rst_word_pc", instr_pc, 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         ready = ($urandom_range(0, 9) < 7);
         stall = ($urandom_range(0, 9) < 3);
         branch_taken = !prev_branch && ($urandom_range(0, 19) == 0);
         prev_branch = branch_taken;
         branch_target = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1023))
                                                      : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
         if (pend.size() == 0) k = $urandom_range(1, 4);
         applyStimulus();
      end
      branch_taken = 1'b0;
      stall = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
